// File: rtl/mem_access_seq.sv
// mem_access_seq: MEM-stage load/store sequencer with a req/gnt/rvalid data port.
// One access at a time: IDLE -> REQ -> (WAIT) -> DONE -> IDLE, with a wait-cycle timeout.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned accesses instead of
// silently clearing the low address bits.
module mem_access_seq #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] inst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_tmo,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              is_mem;
    logic              misal;
    logic              start;
    logic [31:0]       addr_al;
    logic [CNT_W:0]    cnt_inc;
    logic              tmo_hit;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    // Decode the incoming MEM-stage instruction and its alignment.
    always_comb begin
        is_mem = (inst[31:26] == OP_LB)  || (inst[31:26] == OP_LBU) ||
                 (inst[31:26] == OP_LH)  || (inst[31:26] == OP_LHU) ||
                 (inst[31:26] == OP_LW)  || (inst[31:26] == OP_SB)  ||
                 (inst[31:26] == OP_SH)  || (inst[31:26] == OP_SW);
        misal  = ((inst[27:26] == 2'b01) && addr[0]) ||
                 ((inst[27:26] == 2'b11) && (addr[1:0] != 2'b00));
        addr_al = addr;
        if (inst[27:26] == 2'b01) begin
            addr_al[0] = 1'b0;
        end else if (inst[27:26] == 2'b11) begin
            addr_al[1:0] = 2'b00;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned ops never start; they raise an address exception for the cycle.
    assign start    = mem_valid && is_mem && !misal;
    assign exc_adel = !reset && (state_q == S_IDLE) && mem_valid && is_mem && misal && !inst[29];
    assign exc_ades = !reset && (state_q == S_IDLE) && mem_valid && is_mem && misal &&  inst[29];
`else
    logic unused_misal;
    // Misaligned ops proceed with the low address bits cleared.
    assign start        = mem_valid && is_mem;
    assign exc_adel     = 1'b0;
    assign exc_ades     = 1'b0;
    assign unused_misal = misal;
`endif

    logic unused_inst;
    assign unused_inst = ^inst[25:0];

    assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign tmo_hit = (cnt_inc >= (CNT_W + 1)'(MAX_WAIT));

    // Next-state, capture and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
                    size_d  = inst[27:26];
                    we_d    = inst[29];
                    uns_d   = inst[28];
                    addr_d  = addr_al;
                    wdata_d = wdata;
                    rdata_d = '0;
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc[CNT_W-1:0];
                if (dm_gnt) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc[CNT_W-1:0];
                if (dm_rvalid) begin
                    rdata_d = dm_rdata;
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and captured-operand registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory-port and pipeline-control outputs, held stable from the captured op.
    always_comb begin
        stall    = (!reset && (state_q == S_IDLE) && start) ||
                   (state_q == S_REQ) || (state_q == S_WAIT);
        dm_req   = (state_q == S_REQ);
        dm_we    = 1'b0;
        dm_be    = 4'b0000;
        dm_addr  = '0;
        dm_wdata = '0;
        exc_tmo  = (state_q == S_DONE) && tmo_q;
        if (state_q == S_REQ) begin
            dm_we   = we_q;
            dm_addr = {addr_q[31:2], 2'b00};
            dm_be   = 4'b1111;
            if (we_q) begin
                case (size_q)
                    2'b00: begin
                        dm_be    = 4'b0001 << addr_q[1:0];
                        dm_wdata = {4{wdata_q[7:0]}};
                    end
                    2'b01: begin
                        dm_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                        dm_wdata = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        dm_wdata = wdata_q;
                    end
                endcase
            end
        end
    end

    // Load result: lane select and extension, valid only in a non-timeout DONE.
    always_comb begin
        case (addr_q[1:0])
            2'b00:   ld_byte = rdata_q[7:0];
            2'b01:   ld_byte = rdata_q[15:8];
            2'b10:   ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        ld_data = '0;
        if ((state_q == S_DONE) && !tmo_q && !we_q) begin
            case (size_q)
                2'b00:   ld_data = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
                2'b01:   ld_data = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
                default: ld_data = rdata_q;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq: table of single-access vectors plus
// hand-written multi-cycle sequences (latency, timeout, grant/timeout race, reset).
`timescale 1ns/1ps
module tb_mem_access_seq;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_tmo;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [5:0]  opc;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [3:0]  be;
        logic [31:0] dwd;
        logic [31:0] ld;
    } vec_t;

    vec_t vecs[10];

    mem_access_seq #(.MAX_WAIT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .inst      (inst),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .ld_data   (ld_data),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades),
        .exc_tmo   (exc_tmo),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_be     (dm_be),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] wd);
        mem_valid = 1'b1;
        inst      = {opc, 26'h0ABCDE};
        addr      = a;
        wdata     = wd;
    endtask

    // One access with grant in the first REQ cycle and data in the first WAIT cycle.
    task automatic run_op(input vec_t v, input string tag);
        logic is_st;
        is_st = v.opc[3];
        drive_op(v.opc, v.addr, v.wd);
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        check({tag, "_start_stall"}, 32'(stall), 32'd1);
        tick();
        dm_gnt = 1'b1;
        @(negedge clk);
        check({tag, "_req"},  32'(dm_req), 32'd1);
        check({tag, "_we"},   32'(dm_we), 32'(is_st));
        check({tag, "_be"},   32'(dm_be), 32'(v.be));
        check({tag, "_addr"}, dm_addr, {v.addr[31:2], 2'b00});
        if (is_st) check({tag, "_wdata"}, dm_wdata, v.dwd);
        tick();
        dm_gnt = 1'b0;
        if (!is_st) begin
            dm_rvalid = 1'b1; dm_rdata = v.rd;
            @(negedge clk);
            check({tag, "_wait_stall"}, 32'(stall), 32'd1);
            tick();
            dm_rvalid = 1'b0;
        end
        mem_valid = 1'b0;
        @(negedge clk);
        check({tag, "_done_stall"}, 32'(stall), 32'd0);
        check({tag, "_done_tmo"}, 32'(exc_tmo), 32'd0);
        if (!is_st) check({tag, "_ld"}, ld_data, v.ld);
        tick();
        @(negedge clk);
        check({tag, "_idle_ld"}, ld_data, 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   st;
        int   req_cycles;
        vec_t v;

        //           opc        addr          wdata         rdata         be       dm_wdata      ld_data
        vecs[0] = '{6'b100000, 32'h0000_0100, 32'h0,        32'h1234_567F, 4'hF, 32'h0,        32'h0000_007F};
        vecs[1] = '{6'b100000, 32'h0000_0101, 32'h0,        32'h0000_FF00, 4'hF, 32'h0,        32'hFFFF_FFFF};
        vecs[2] = '{6'b100100, 32'h0000_0102, 32'h0,        32'h00AB_0000, 4'hF, 32'h0,        32'h0000_00AB};
        vecs[3] = '{6'b100001, 32'h0000_0202, 32'h0,        32'h8001_1234, 4'hF, 32'h0,        32'hFFFF_8001};
        vecs[4] = '{6'b100101, 32'h0000_0200, 32'h0,        32'h1234_9ABC, 4'hF, 32'h0,        32'h0000_9ABC};
        vecs[5] = '{6'b100011, 32'h8000_0304, 32'h0,        32'hDEAD_BEEF, 4'hF, 32'h0,        32'hDEAD_BEEF};
        vecs[6] = '{6'b101000, 32'h0000_0401, 32'h1122_3344, 32'h0,         4'h2, 32'h4444_4444, 32'h0};
        vecs[7] = '{6'b101000, 32'h0000_0403, 32'h0000_00A5, 32'h0,         4'h8, 32'hA5A5_A5A5, 32'h0};
        vecs[8] = '{6'b101001, 32'h0000_0400, 32'hAAAA_5555, 32'h0,         4'h3, 32'h5555_5555, 32'h0};
        vecs[9] = '{6'b101011, 32'h0000_0408, 32'hCAFE_F00D, 32'h0,         4'hF, 32'hCAFE_F00D, 32'h0};

        // Reset with a valid op presented: everything must stay quiet.
        reset = 1'b0; dm_gnt = 1'b1; dm_rvalid = 1'b0; dm_rdata = 32'h0;
        drive_op(6'b100011, 32'h0, 32'h0);
        #1 reset = 1'b1;
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(dm_req), 32'd0);
        check("rst_we", 32'(dm_we), 32'd0);
        check("rst_be", 32'(dm_be), 32'd0);
        check("rst_ld", ld_data, 32'd0);
        check("rst_tmo", 32'(exc_tmo), 32'd0);
        check("rst_adel", 32'(exc_adel), 32'd0);
        check("rst_ades", 32'(exc_ades), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_after_edges", 32'(dm_req), 32'd0);
        mem_valid = 1'b0; dm_gnt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Table of single accesses.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], $sformatf("v%0d", i));
        end

        // lb at 0x3: grant in 2nd REQ cycle (rvalid there ignored), data next cycle.
        st = 0;
        drive_op(6'b100000, 32'h0000_0003, 32'h0);
        dm_gnt = 1'b0; dm_rvalid = 1'b0;
        @(negedge clk); if (stall) st++;
        tick();
        @(negedge clk); if (stall) st++;
        check("lb_req1", 32'(dm_req), 32'd1);
        tick();
        dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h0000_0011;
        @(negedge clk); if (stall) st++;
        tick();
        dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h8000_0000;
        @(negedge clk); if (stall) st++;
        tick();
        dm_rvalid = 1'b0; mem_valid = 1'b0;
        @(negedge clk); if (stall) st++;
        check("lb_ld", ld_data, 32'hFFFF_FF80);
        check("lb_stall_cycles", 32'(st), 32'd4);
        tick();

        // sh at 0x2 with immediate grant.
        st = 0;
        drive_op(6'b101001, 32'h0000_0002, 32'h1234_ABCD);
        @(negedge clk); if (stall) st++;
        tick();
        dm_gnt = 1'b1;
        @(negedge clk); if (stall) st++;
        check("sh_be", 32'(dm_be), 32'hC);
        check("sh_wdata", dm_wdata, 32'hABCD_ABCD);
        check("sh_we", 32'(dm_we), 32'd1);
        tick();
        dm_gnt = 1'b0; mem_valid = 1'b0;
        @(negedge clk); if (stall) st++;
        check("sh_stall_cycles", 32'(st), 32'd2);
        tick();

        // lw never granted: timeout after 15 REQ cycles.
        drive_op(6'b100011, 32'h0000_0010, 32'h0);
        req_cycles = 0;
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            tick();
            @(negedge clk);
            if (dm_req) req_cycles++;
            else break;
        end
        mem_valid = 1'b0;
        check("tmo_req_cycles", 32'(req_cycles), 32'd15);
        check("tmo_exc", 32'(exc_tmo), 32'd1);
        check("tmo_ld", ld_data, 32'd0);
        check("tmo_stall", 32'(stall), 32'd0);
        tick();
        @(negedge clk);
        check("tmo_clear", 32'(exc_tmo), 32'd0);
        tick();

        // sw granted in the 15th REQ cycle: grant beats the timeout.
        drive_op(6'b101011, 32'h0000_0020, 32'h0000_0001);
        for (int k = 1; k <= 15; k++) begin
            tick();
            dm_gnt = (k == 15);
        end
        @(negedge clk);
        check("race_req", 32'(dm_req), 32'd1);
        tick();
        dm_gnt = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        check("race_tmo", 32'(exc_tmo), 32'd0);
        check("race_stall", 32'(stall), 32'd0);
        tick();

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned lw / sh trap without issuing a request.
        drive_op(6'b100011, 32'h0000_0006, 32'h0);
        @(negedge clk);
        check("mis_lw_adel", 32'(exc_adel), 32'd1);
        check("mis_lw_ades", 32'(exc_ades), 32'd0);
        check("mis_lw_req", 32'(dm_req), 32'd0);
        check("mis_lw_stall", 32'(stall), 32'd0);
        tick();
        @(negedge clk);
        check("mis_lw_req_next", 32'(dm_req), 32'd0);
        drive_op(6'b101001, 32'h0000_0001, 32'h0);
        @(negedge clk);
        check("mis_sh_ades", 32'(exc_ades), 32'd1);
        check("mis_sh_adel", 32'(exc_adel), 32'd0);
        mem_valid = 1'b0;
        tick();
`else
        // Misaligned accesses proceed with low address bits cleared.
        v = '{6'b100011, 32'h0000_0006, 32'h0, 32'h89AB_CDEF, 4'hF, 32'h0, 32'h89AB_CDEF};
        run_op(v, "mis_lw");
        check("mis_lw_noexc", 32'(exc_adel), 32'd0);
        v = '{6'b100001, 32'h0000_0003, 32'h0, 32'hFFEE_1122, 4'hF, 32'h0, 32'hFFFF_FFEE};
        run_op(v, "mis_lh");
`endif

        // Reset asserted in WAIT takes effect before the next edge.
        drive_op(6'b100011, 32'h0000_0040, 32'h0);
        tick();
        dm_gnt = 1'b1;
        tick();
        dm_gnt = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rstw_req", 32'(dm_req), 32'd0);
        check("rstw_stall", 32'(stall), 32'd0);
        check("rstw_be", 32'(dm_be), 32'd0);
        mem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        v = '{6'b100100, 32'h0000_0001, 32'h0, 32'h0000_8000, 4'hF, 32'h0, 32'h0000_0080};
        run_op(v, "post_rst_lbu");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
